// File: rtl/pipe_pkg.sv
// Shared constants for the generic pipeline stage register: boot PC, rewind step,
// stage-state encodings ({skid_v, main_v}) and the NOP control word shown on bubbles.
package pipe_pkg;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;
  localparam int          PC_STEP_DEFAULT  = 4;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b11;

  localparam logic [31:0] NOP_CTRL = 32'h0;
endpackage

// File: rtl/pipe_sat_counter.sv
// Width-parametrised saturating up-counter; async active-low reset to zero.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage register with 2-entry skid buffer, flush bubble and PC rewind.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAGE_STAT_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  logic              r_main_v;
  logic [DATA_W-1:0] r_main_d;
  logic [PC_W-1:0]   r_main_pc;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_d;
  logic [PC_W-1:0]   r_skid_pc;

  logic            w_in_fire;
  logic            w_out_fire;
  logic [PC_W-1:0] w_rewind_pc;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready   = ~r_skid_v;
  assign w_in_fire  = in_valid & ~r_skid_v;
  assign w_out_fire = r_main_v & out_ready;

  // A PC with only the kernel bit (or nothing) set is not rewound, avoiding underflow
  assign w_rewind_pc = (in_pc[PC_W-2:0] == '0) ? in_pc : (in_pc - PC_W'(PC_STEP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_v  <= 1'b0;
      r_main_d  <= '0;
      r_main_pc <= PC_RESET;
      r_skid_v  <= 1'b0;
      r_skid_d  <= '0;
      r_skid_pc <= PC_RESET;
    end else if (flush) begin
      r_main_v  <= 1'b0;
      r_main_d  <= '0;
      r_main_pc <= w_rewind_pc;
      r_skid_v  <= 1'b0;
      r_skid_d  <= '0;
    end else begin
      case ({r_skid_v, r_main_v})
        EMPTY: begin
          if (w_in_fire) begin
            r_main_v  <= 1'b1;
            r_main_d  <= in_data;
            r_main_pc <= in_pc;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_d  <= in_data;
            r_main_pc <= in_pc;
          end else if (w_in_fire) begin
            r_skid_v  <= 1'b1;
            r_skid_d  <= in_data;
            r_skid_pc <= in_pc;
          end else if (w_out_fire) begin
            r_main_v <= 1'b0;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main_d  <= r_skid_d;
            r_main_pc <= r_skid_pc;
            r_skid_v  <= 1'b0;
          end
        end
        default: begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_main_v;
  assign out_data  = r_main_v ? r_main_d : DATA_W'(NOP_CTRL);
  assign out_pc    = r_main_pc;

`ifdef PIPE_STAGE_STAT_EN
  pipe_sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (r_main_v & ~out_ready),
    .o_cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (flush),
    .o_cnt (flush_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (default widths).
module tb_pipe_stage_skid;
  localparam int DATA_W = 128;
  localparam int PC_W   = 32;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
`ifdef PIPE_STAGE_STAT_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc)
`ifdef PIPE_STAGE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hFF;
    in_pc     = 32'h1234_5678;
    flush     = 1'b0;
    out_ready = 1'b0;

    // 1. Reset state, then first transfer
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_pc",    128'(out_pc),    128'h8000_0000);
    chk("rst_out_data",  out_data,        128'd0);

    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 128'hA5;
    in_pc    = 32'h0040_0004;
    tick();
    chk("first_valid", 128'(out_valid), 128'd1);
    chk("first_data",  out_data,        128'hA5);
    chk("first_pc",    128'(out_pc),    128'h0040_0004);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("first_drain", 128'(out_valid), 128'd0);

    // 2. Streaming 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      in_pc    = 32'h0040_0000 + 32'(4 * i);
      chk("stream_in_ready", 128'(in_ready), 128'd1);
      tick();
      chk("stream_valid", 128'(out_valid), 128'd1);
      chk("stream_data",  out_data,        128'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 128'(out_valid), 128'd0);

    // 3. Back-pressure into the skid slot
    in_valid = 1'b1; in_data = 128'd1; out_ready = 1'b1;
    tick();
    chk("bp_d1", out_data, 128'd1);
    out_ready = 1'b0; in_data = 128'd2;
    tick();
    chk("bp_in_ready_two", 128'(in_ready), 128'd0);
    chk("bp_hold1",        out_data,       128'd1);
    in_data = 128'd3;
    tick();
    chk("bp_hold1b",  out_data,        128'd1);
    chk("bp_stall_rdy", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_d2",      out_data,         128'd2);
    chk("bp_rdy_one", 128'(in_ready),   128'd1);
    tick();
    chk("bp_d3", out_data, 128'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", 128'(out_valid), 128'd0);

    // 4. Flush while holding two payloads
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11;
    tick();
    in_data = 128'h22;
    tick();
    chk("fl_two_rdy", 128'(in_ready), 128'd0);
    flush = 1'b1; in_data = 128'h33; in_pc = 32'h0040_0010;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid",    128'(out_valid), 128'd0);
    chk("fl_in_ready", 128'(in_ready),  128'd1);
    chk("fl_data",     out_data,        128'd0);
    chk("fl_pc",       128'(out_pc),    128'h0040_000C);
    tick();
    chk("fl_pc_keep", 128'(out_pc),    128'h0040_000C);
    chk("fl_empty",   128'(out_valid), 128'd0);

    // 5. Rewind boundaries
    flush = 1'b1; in_pc = 32'h8000_0000;
    tick();
    chk("rw_kernel", 128'(out_pc), 128'h8000_0000);
    in_pc = 32'h0000_0000;
    tick();
    chk("rw_zero", 128'(out_pc), 128'h0);
    in_pc = 32'h0000_0004;
    tick();
    chk("rw_four", 128'(out_pc), 128'h0);
    flush = 1'b0;

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; in_data = 128'h44; in_pc = 32'h0040_0100;
    tick();
    chk("ar_loaded", 128'(out_valid), 128'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'd0);
    chk("ar_pc",    128'(out_pc),    128'h8000_0000);
    chk("ar_data",  out_data,        128'd0);
    tick();
    reset = 1'b1;

`ifdef PIPE_STAGE_STAT_EN
    // 6. Statistics counters
    chk("st_rst_stall", 128'(stall_cnt), 128'd0);
    chk("st_rst_flush", 128'(flush_cnt), 128'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h55;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1; flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    chk("st_stall3", 128'(stall_cnt), 128'd3);
    chk("st_flush2", 128'(flush_cnt), 128'd2);
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    chk("st_stall_sat", 128'(stall_cnt), 128'hFFFF);
    chk("st_flush_kept", 128'(flush_cnt), 128'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
